// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_pkg
// Description : Shared types and constants for the instruction-fetch
//               controller (state encoding, self-loop opcode, PC step).
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    // Fetch FSM state encoding (2-bit)
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } ifetch_state_e;

    // jal x0,0 : a jump to itself, treated as "program finished"
    localparam logic [31:0] SELF_LOOP_INST = 32'h0000_006f;

    // Sequential PC increment (one 32-bit instruction)
    localparam logic [31:0] PC_INC = 32'd4;

endpackage : ifetch_pkg
`default_nettype wire

// File: rtl/ifetch_npc.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_npc
// Description : Combinational next-PC select (redirect > stall/self-loop
//               hold > pc+4) plus alignment and memory-range fault check of
//               the selected next PC.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_npc
    import ifetch_pkg::*;
#(
    parameter int IMEM_BYTES = 256
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] im_inst,
    output logic [31:0] npc,
    output logic        npc_fault,
    output logic        self_loop
);

    localparam logic [31:0] C_IMEM_LIMIT = 32'(IMEM_BYTES);

    // Pick the next PC and flag it if it is misaligned or outside the memory
    always_comb begin
        self_loop = (im_inst == SELF_LOOP_INST) && !stall && !redirect_valid;
        if (redirect_valid) begin
            npc = redirect_pc;
        end else if (stall || self_loop) begin
            npc = pc;
        end else begin
            npc = pc + PC_INC;
        end
        npc_fault = (npc[1:0] != 2'b00) || (npc >= C_IMEM_LIMIT);
    end

endmodule : ifetch_npc
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_ctrl
// Description : Instruction-fetch controller. Owns the PC, drives the
//               combinational instruction memory and sequences fetch through
//               IDLE / RUN / HALT / FAULT.
//               Optional macro IFETCH_PERF_CNT_EN adds the fetch_count output
//               (unstalled RUN cycles, wraps at 2^32).
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        resume_req,
    output logic        im_ce,
    output logic [31:0] im_addr,
    input  logic [31:0] im_inst,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        halted,
    output logic        fault
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    ifetch_state_e r_state;
    ifetch_state_e w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_nxt;
    logic [31:0]   w_npc;
    logic          w_npc_fault;
    logic          w_self_loop;

    ifetch_npc #(
        .IMEM_BYTES (IMEM_BYTES)
    ) u_npc (
        .pc             (r_pc),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .im_inst        (im_inst),
        .npc            (w_npc),
        .npc_fault      (w_npc_fault),
        .self_loop      (w_self_loop)
    );

    // State and PC registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next state / next PC and outputs decoded from the registered state
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        im_ce       = 1'b0;
        inst_valid  = 1'b0;
        inst_out    = 32'h0;
        halted      = 1'b0;
        fault       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                im_ce      = 1'b1;
                inst_valid = 1'b1;
                inst_out   = im_inst;
                // PC always follows the selection, even into FAULT (debug aid)
                w_pc_nxt   = w_npc;
                if (w_npc_fault) begin
                    w_state_nxt = ST_FAULT;
                end else if (w_self_loop || halt_req) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                // a still-asserted halt_req keeps us parked
                if (resume_req && !halt_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

    assign im_addr = r_pc;
    assign pc_out  = r_pc;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_fetch_count;

    // Count unstalled RUN cycles; frozen outside RUN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_count <= 32'h0;
        end else if ((r_state == ST_RUN) && !stall) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    // No performance counter in this build
`endif

endmodule : ifetch_ctrl
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_ctrl
// Description : Self-checking bench for ifetch_ctrl: directed scenarios then
//               randomized traffic, compared every cycle with a behavioural
//               fetch model. Honors IFETCH_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_HALT  = 2;
    localparam int M_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        resume_req;
    logic        im_ce;
    logic [31:0] im_addr;
    logic [31:0] im_inst;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        halted;
    logic        fault;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif

    logic [31:0] mem [64];

    int          n_checks = 0;
    int          n_errors = 0;

    // behavioural model state
    int          m_mode;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    always #5 clk = ~clk;

    assign im_inst = mem[im_addr[7:2]];

    ifetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (256)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .resume_req     (resume_req),
        .im_ce          (im_ce),
        .im_addr        (im_addr),
        .im_inst        (im_inst),
        .inst_valid     (inst_valid),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .halted         (halted),
        .fault          (fault)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: one clock edge worth of the fetch rules
    task automatic model_step(input logic rn, input logic s, input logic rv,
                              input logic [31:0] rpc, input logic hr, input logic rr);
        logic [31:0] word;
        logic [31:0] target;
        logic        loop;
        word = mem[m_pc[7:2]];
        if (!rn) begin
            m_mode = M_IDLE;
            m_pc   = 32'h0;
            m_cnt  = 32'h0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (!s) m_cnt = m_cnt + 1;
            loop = (word == 32'h6f) && !s && !rv;
            if (rv)            target = rpc;
            else if (s || loop) target = m_pc;
            else               target = m_pc + 4;
            m_pc = target;
            if ((target % 4) != 0 || target >= 256) m_mode = M_FAULT;
            else if (loop || hr)                    m_mode = M_HALT;
        end else if (m_mode == M_HALT) begin
            if (rr && !hr) m_mode = M_RUN;
        end
    endtask

    task automatic compare_all();
        logic        run;
        run = (m_mode == M_RUN);
        check_eq("pc_out",     pc_out,     m_pc);
        check_eq("im_addr",    im_addr,    m_pc);
        check_eq("im_ce",      {31'b0, im_ce},      {31'b0, run});
        check_eq("inst_valid", {31'b0, inst_valid}, {31'b0, run});
        check_eq("inst_out",   inst_out,   run ? mem[m_pc[7:2]] : 32'h0);
        check_eq("halted",     {31'b0, halted},     {31'b0, m_mode == M_HALT});
        check_eq("fault",      {31'b0, fault},      {31'b0, m_mode == M_FAULT});
`ifdef IFETCH_PERF_CNT_EN
        check_eq("fetch_count", fetch_count, m_cnt);
`endif
    endtask

    // Drive one cycle of inputs at negedge, clock it, then compare at negedge
    task automatic cycle(input logic rn, input logic s, input logic rv,
                         input logic [31:0] rpc, input logic hr, input logic rr);
        rst_n          = rn;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt_req       = hr;
        resume_req     = rr;
        @(posedge clk);
        model_step(rn, s, rv, rpc, hr, rr);
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] tgt;
        int          sel;
        logic        rn;

        for (int i = 0; i < 64; i++) begin
            mem[i] = $urandom;
            if (mem[i] == 32'h6f) mem[i] = 32'h13;
        end
        mem[20] = 32'h0000_006f;
        m_mode = M_IDLE;
        m_pc   = 32'h0;
        m_cnt  = 32'h0;

        @(negedge clk);
        // reset and free run
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("rst_im_ce", {31'b0, im_ce}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);   // leave IDLE
        check_eq("first_valid", {31'b0, inst_valid}, 32'h1);
        run_n(4);
        check_eq("free_run_pc", pc_out, 32'h10);

        // stall then redirect during stall
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("stall_pc", pc_out, 32'h10);
        cycle(1'b1, 1'b1, 1'b1, 32'h2c, 1'b0, 1'b0);
        check_eq("redir_wins", pc_out, 32'h2c);

        // self-loop halt at 0x50 and resume
        cycle(1'b1, 1'b0, 1'b1, 32'h48, 1'b0, 1'b0);
        run_n(3);
        check_eq("loop_halted", {31'b0, halted}, 32'h1);
        check_eq("loop_pc", pc_out, 32'h50);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("resume_valid", {31'b0, inst_valid}, 32'h1);
        run_n(1);
        check_eq("rehalt", {31'b0, halted}, 32'h1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("halt_and_resume", {31'b0, halted}, 32'h1);

        // halt_req together with redirect
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
        check_eq("halt_redir_pc", pc_out, 32'h40);
        check_eq("halt_redir_h", {31'b0, halted}, 32'h1);

        // faults
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 32'h102, 1'b0, 1'b0);
        check_eq("misalign_fault", {31'b0, fault}, 32'h1);
        check_eq("misalign_pc", pc_out, 32'h102);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("fault_sticky", {31'b0, fault}, 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("fault_cleared", {31'b0, fault}, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        check_eq("range_fault", {31'b0, fault}, 32'h1);

        // counter scenario: 10 unstalled RUN, 2 stalled, 3 HALT
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        run_n(9);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        run_n(3);
        check_eq("cnt_scn_pc", pc_out, 32'h28);
`ifdef IFETCH_PERF_CNT_EN
        check_eq("fetch_count_10", fetch_count, 32'd10);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       tgt = 32'h102;
                1:       tgt = 32'h100;
                2:       tgt = 32'h50;
                3:       tgt = 32'hffff_fffc;
                default: tgt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            endcase
            if (m_mode == M_FAULT) rn = ($urandom_range(0, 9) != 0);
            else                   rn = ($urandom_range(0, 99) >= 2);
            cycle(rn,
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) == 0),
                  tgt,
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_ifetch_ctrl
`default_nettype wire
